dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single-port, byte-selectable data RAM between two requesters.
- Master 0 is the MEM-stage load/store port. Master 1 is a secondary port for debug/DMA loads.
- Sequences each access as a fixed three-state transaction and returns registered read data with a one-cycle ack.
- Generates a pipeline stall request for master 0 while its access is outstanding.

Parameters:
- ADDR_W, 32, address width (equals DataAddrBus width)
- DATA_W, 32, data width (equals DataBus width; sel width is DATA_W/8 = 4)

Ports:
- clk  in  1  clock; everything updates on the rising edge
- rst  in  1  synchronous, active-high reset
- m0_req_i  in  1  master 0 request; held high with fields stable until m0_ack_o
- m0_we_i  in  1  master 0 write enable
- m0_addr_i  in  ADDR_W  master 0 byte address
- m0_sel_i  in  4  master 0 byte lane select
- m0_data_i  in  DATA_W  master 0 write data
- m0_data_o  out  DATA_W  master 0 read data
- m0_ack_o  out  1  master 0 completion pulse
- m0_stallreq_o  out  1  stall request to pipeline control
- m1_req_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i, m1_data_o, m1_ack_o: same as the master 0 ports, for master 1
- ram_ce_o  out  1  RAM chip enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM address
- ram_sel_o  out  4  RAM byte select
- ram_data_o  out  DATA_W  RAM write data
- ram_data_i  in  DATA_W  RAM read data (combinational from RAM, valid while ce=1 and we=0)

Behaviour:
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req_i is high, select a winner and latch its we/addr/sel/data and grant id, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly one cycle):
  - ram_ce_o=1; ram_we/addr/sel/data driven from the latch.
  - The RAM write commits on the closing edge.
  - For a read, ram_data_i is captured into the granted master's data_o register on that edge.
  - Next state is DONE.
- DONE (exactly one cycle):
  - Granted master's ack_o=1.
  - Requests are not sampled in this state.
  - Next state is IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle N: ACCESS is cycle N+1, ack and valid data are at cycle N+2.
  - One access per 3 cycles.
- m*_data_o keeps its value until that master's next read completes. Writes leave data_o unchanged.
- Whenever state != ACCESS, RAM outputs are ram_ce_o=0, ram_we_o=0, and addr/sel/data = 0.
- m0_stallreq_o = m0_req_i AND NOT m0_ack_o (combinational).
- Simultaneous requests in IDLE: master 0 wins unless the Optional Feature is enabled. The loser stays pending and is served in the next IDLE.
- Requester drops req during ACCESS/DONE: the access still completes and ack is still issued.
- Reset:
  - On an edge with rst=1: state=IDLE, latch cleared, both data_o=0, both ack=0, last-grant=master 1.
  - ram_ce_o is gated with NOT rst, so no RAM write occurs during any reset cycle, including reset asserted mid-ACCESS. An interrupted access is dropped and not acked.
- sel=0000 with we=1: a legal no-op write. The FSM still runs and acks.

Optional Feature:
- Macro DRAM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-grant register records the most recent winner; on a simultaneous request the other master wins.
- Undefined: fixed priority, master 0 always wins; the last-grant register is not built.

Decomposition:
- Shared defines:
  - FSM state encodings (ARB_IDLE=2'b00, ARB_ACCESS=2'b01, ARB_DONE=2'b10)
  - Master id constants
  - The existing ZeroWord/DataBus/DataAddrBus macros
- One sub-module is natural: dram_arb_pick, a combinational grant selector taking the two reqs and last-grant and returning the grant id.

Test Plan:
- Master 0 write addr 0x10, sel 1111, data 0xDEADBEEF, then read 0x10 -> m0_ack_o at N+2 for both; read m0_data_o=0xDEADBEEF; m0_stallreq_o high for exactly 2 cycles per access.
- Master 1 byte write sel 0100, data 0x00AA0000 to 0x10, then master 0 read -> 0xDEAABEEF.
- Both masters request reads in the same cycle -> without DRAM_ARB_RR_EN, m0 acks at N+2 and m1 at N+5. With it, the second simultaneous pair is granted to m1 first.
- rst asserted during ACCESS of a write of 0x12345678 to 0x20 -> no ack; a read of 0x20 after reset returns the pre-write value; all outputs 0 in the cycle after reset.
- Master 0 drops req during ACCESS -> ack still pulses once; FSM returns to IDLE; no second access.
- Back-to-back m0 reads of 0x10 and 0x14 with req held -> ack pulses at N+2 and N+5; ram_ce_o high only at N+1 and N+4.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// Shared types and constants for the two-master data RAM arbiter.
package dram_arbiter_pkg;

  localparam int DATA_BUS_W      = 32;
  localparam int DATA_ADDR_BUS_W = 32;
  localparam logic [DATA_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ACCESS = 2'b01,
    ARB_DONE   = 2'b10
  } arb_state_e;

  function automatic logic other_id(input logic id);
    return (id == M0_ID) ? M1_ID : M0_ID;
  endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
interface dram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [SEL_W-1:0]  m0_sel_i;
  logic [DATA_W-1:0] m0_data_i;
  logic [DATA_W-1:0] m0_data_o;
  logic              m0_ack_o;
  logic              m0_stallreq_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [SEL_W-1:0]  m1_sel_i;
  logic [DATA_W-1:0] m1_data_i;
  logic [DATA_W-1:0] m1_data_o;
  logic              m1_ack_o;

  logic              ram_ce_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [SEL_W-1:0]  ram_sel_o;
  logic [DATA_W-1:0] ram_data_o;
  logic [DATA_W-1:0] ram_data_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_sel_i, m0_data_i,
    output m0_data_o, m0_ack_o, m0_stallreq_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i,
    output m1_data_o, m1_ack_o,
    output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
    input  ram_data_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_sel_i, m0_data_i,
    input  m0_data_o, m0_ack_o, m0_stallreq_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i,
    input  m1_data_o, m1_ack_o,
    input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
    output ram_data_i
  );

endinterface

// File: rtl/dram_arb_pick.sv
// Combinational grant selector; on a tie the master other than i_last wins.
// With DRAM_ARB_RR_EN undefined the top ties i_last to master 1, giving fixed priority to master 0.
module dram_arb_pick
  import dram_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_grant
);

  // grant decision
  always_comb begin
    o_grant = M0_ID;
    if (i_req0 && i_req1) begin
      o_grant = other_id(i_last);
    end else if (i_req1) begin
      o_grant = M1_ID;
    end else begin
      o_grant = M0_ID;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Two-master arbiter for the single-port data RAM: IDLE -> ACCESS -> DONE per transaction.
// Macro DRAM_ARB_RR_EN selects round-robin tie-breaking; undefined gives master 0 fixed priority.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DATA_ADDR_BUS_W,
  parameter int DATA_W = DATA_BUS_W
)(
  input  logic           clk,
  input  logic           rst,
  dram_arbiter_if.slave  bus
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_data;
  logic              r_gnt;
  logic [DATA_W-1:0] r_m0_data;
  logic [DATA_W-1:0] r_m1_data;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic              w_gnt;
  logic              w_last;
  logic              w_any_req;
  logic              w_latch;

  assign w_any_req = bus.m0_req_i | bus.m1_req_i;
  assign w_latch   = (r_state == ARB_IDLE) && w_any_req;

`ifdef DRAM_ARB_RR_EN
  logic r_last;

  // most recent winner, used to alternate on ties
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= M1_ID;
    end else if (w_latch) begin
      r_last <= w_gnt;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = M1_ID;
`endif

  dram_arb_pick u_pick (
    .i_req0  (bus.m0_req_i),
    .i_req1  (bus.m1_req_i),
    .i_last  (w_last),
    .o_grant (w_gnt)
  );

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:   w_next = w_any_req ? ARB_ACCESS : ARB_IDLE;
      ARB_ACCESS: w_next = ARB_DONE;
      ARB_DONE:   w_next = ARB_IDLE;
      default:    w_next = ARB_IDLE;
    endcase
  end

  // state, request latch, read-data capture and ack registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_we      <= 1'b0;
      r_addr    <= {ADDR_W{1'b0}};
      r_sel     <= {SEL_W{1'b0}};
      r_data    <= {DATA_W{1'b0}};
      r_gnt     <= M0_ID;
      r_m0_data <= {DATA_W{1'b0}};
      r_m1_data <= {DATA_W{1'b0}};
      r_m0_ack  <= 1'b0;
      r_m1_ack  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_gnt  <= w_gnt;
        r_we   <= (w_gnt == M1_ID) ? bus.m1_we_i   : bus.m0_we_i;
        r_addr <= (w_gnt == M1_ID) ? bus.m1_addr_i : bus.m0_addr_i;
        r_sel  <= (w_gnt == M1_ID) ? bus.m1_sel_i  : bus.m0_sel_i;
        r_data <= (w_gnt == M1_ID) ? bus.m1_data_i : bus.m0_data_i;
      end
      if ((r_state == ARB_ACCESS) && !r_we) begin
        if (r_gnt == M1_ID) begin
          r_m1_data <= bus.ram_data_i;
        end else begin
          r_m0_data <= bus.ram_data_i;
        end
      end
      r_m0_ack <= (r_state == ARB_ACCESS) && (r_gnt == M0_ID);
      r_m1_ack <= (r_state == ARB_ACCESS) && (r_gnt == M1_ID);
    end
  end

  // RAM drive only in ACCESS; chip enable is blocked while reset is asserted
  always_comb begin
    bus.ram_ce_o   = 1'b0;
    bus.ram_we_o   = 1'b0;
    bus.ram_addr_o = {ADDR_W{1'b0}};
    bus.ram_sel_o  = {SEL_W{1'b0}};
    bus.ram_data_o = {DATA_W{1'b0}};
    if (r_state == ARB_ACCESS) begin
      bus.ram_ce_o   = ~rst;
      bus.ram_we_o   = r_we;
      bus.ram_addr_o = r_addr;
      bus.ram_sel_o  = r_sel;
      bus.ram_data_o = r_data;
    end else begin
      bus.ram_ce_o   = 1'b0;
    end
  end

  assign bus.m0_data_o     = r_m0_data;
  assign bus.m1_data_o     = r_m1_data;
  assign bus.m0_ack_o      = r_m0_ack;
  assign bus.m1_ack_o      = r_m1_ack;
  assign bus.m0_stallreq_o = bus.m0_req_i & ~r_m0_ack;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a byte-lane RAM model; checks cycle-exact ack/ce timing and data.
module tb_dram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_init = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_d0;
  logic [31:0] exp_d1;
  logic        first_m;

  logic [31:0] mem [0:63];

  dram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM model: word i initialised to {4{i}}, byte-lane writes on the rising edge
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= {4{8'(i)}};
    end else if (bus.ram_ce_o && bus.ram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_sel_o[b]) mem[bus.ram_addr_o[7:2]][b*8 +: 8] <= bus.ram_data_o[b*8 +: 8];
    end
  end

  assign bus.ram_data_i = (bus.ram_ce_o && !bus.ram_we_o) ? mem[bus.ram_addr_o[7:2]] : 32'h0000_0000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
    if (m) begin
      bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr;
      bus.m1_sel_i = sel; bus.m1_data_i = data;
    end else begin
      bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr;
      bus.m0_sel_i = sel; bus.m0_data_i = data;
    end
  endtask

  // single access, request held until ack; checks cycles N, N+1, N+2
  task automatic access(input string tag, input logic m, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wdata, input logic [31:0] exp_rd);
    to_drive();
    drive(m, 1'b1, we, addr, sel, wdata);
    to_sample();
    check_val({tag, "_n_ce"}, {31'b0, bus.ram_ce_o}, 32'd0);
    check_val({tag, "_n_ack"}, {31'b0, m ? bus.m1_ack_o : bus.m0_ack_o}, 32'd0);
    if (!m) check_val({tag, "_n_stall"}, {31'b0, bus.m0_stallreq_o}, 32'd1);
    to_drive();
    to_sample();
    check_val({tag, "_n1_ce"}, {31'b0, bus.ram_ce_o}, 32'd1);
    check_val({tag, "_n1_we"}, {31'b0, bus.ram_we_o}, {31'b0, we});
    check_val({tag, "_n1_addr"}, bus.ram_addr_o, addr);
    check_val({tag, "_n1_sel"}, {28'b0, bus.ram_sel_o}, {28'b0, sel});
    if (we) check_val({tag, "_n1_wdata"}, bus.ram_data_o, wdata);
    check_val({tag, "_n1_ack"}, {31'b0, m ? bus.m1_ack_o : bus.m0_ack_o}, 32'd0);
    if (!m) check_val({tag, "_n1_stall"}, {31'b0, bus.m0_stallreq_o}, 32'd1);
    to_drive();
    to_sample();
    check_val({tag, "_n2_ack"}, {31'b0, m ? bus.m1_ack_o : bus.m0_ack_o}, 32'd1);
    check_val({tag, "_n2_other_ack"}, {31'b0, m ? bus.m0_ack_o : bus.m1_ack_o}, 32'd0);
    check_val({tag, "_n2_ce"}, {31'b0, bus.ram_ce_o}, 32'd0);
    check_val({tag, "_n2_data"}, m ? bus.m1_data_o : bus.m0_data_o, exp_rd);
    if (!m) check_val({tag, "_n2_stall"}, {31'b0, bus.m0_stallreq_o}, 32'd0);
    to_drive();
    drive(m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) to_drive();
    tb_init = 1'b0;
    rst = 1'b0;
    to_sample();
    check_val("rst_m0_data", bus.m0_data_o, 32'h0);
    check_val("rst_m1_data", bus.m1_data_o, 32'h0);
    check_val("rst_acks", {30'b0, bus.m1_ack_o, bus.m0_ack_o}, 32'h0);
    check_val("rst_ce_we", {30'b0, bus.ram_ce_o, bus.ram_we_o}, 32'h0);
    check_val("rst_addr", bus.ram_addr_o, 32'h0);
    exp_d0 = 32'h0;
    exp_d1 = 32'h0;

    access("m0_wr", 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, exp_d0);
    exp_d0 = 32'hDEAD_BEEF;
    access("m0_rd", 1'b0, 1'b0, 32'h10, 4'hF, 32'h0, exp_d0);
    access("m1_bwr", 1'b1, 1'b1, 32'h10, 4'b0100, 32'h00AA_0000, exp_d1);
    exp_d0 = 32'hDEAA_BEEF;
    access("m0_rd2", 1'b0, 1'b0, 32'h10, 4'hF, 32'h0, exp_d0);

    // simultaneous reads; under round-robin the last winner was m0, so m1 goes first
`ifdef DRAM_ARB_RR_EN
    first_m = 1'b1;
`else
    first_m = 1'b0;
`endif
    to_drive();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    for (int c = 0; c < 7; c++) begin
      to_sample();
      check_val($sformatf("pair_ack0_c%0d", c), {31'b0, bus.m0_ack_o},
                {31'b0, c == (first_m ? 5 : 2)});
      check_val($sformatf("pair_ack1_c%0d", c), {31'b0, bus.m1_ack_o},
                {31'b0, c == (first_m ? 2 : 5)});
      to_drive();
      if (c == 2) drive(first_m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      if (c == 5) drive(~first_m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end
    exp_d1 = 32'h0808_0808;
    check_val("pair_m0_data", bus.m0_data_o, exp_d0);
    check_val("pair_m1_data", bus.m1_data_o, exp_d1);

    access("noop_wr", 1'b0, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, exp_d0);
    access("noop_rd", 1'b0, 1'b0, 32'h10, 4'hF, 32'h0, exp_d0);

    // m0 drops its request during ACCESS
    to_drive();
    drive(1'b0, 1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
    for (int c = 0; c < 6; c++) begin
      to_sample();
      check_val($sformatf("drop_ack_c%0d", c), {31'b0, bus.m0_ack_o}, {31'b0, c == 2});
      check_val($sformatf("drop_ce_c%0d", c), {31'b0, bus.ram_ce_o}, {31'b0, c == 1});
      to_drive();
      if (c == 0) drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end
    exp_d0 = 32'h0505_0505;
    check_val("drop_data", bus.m0_data_o, exp_d0);

    // back-to-back m0 reads with request held
    to_drive();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    for (int c = 0; c < 7; c++) begin
      to_sample();
      check_val($sformatf("b2b_ack_c%0d", c), {31'b0, bus.m0_ack_o}, {31'b0, (c == 2) || (c == 5)});
      check_val($sformatf("b2b_ce_c%0d", c), {31'b0, bus.ram_ce_o}, {31'b0, (c == 1) || (c == 4)});
      if (c == 2) check_val("b2b_data1", bus.m0_data_o, 32'hDEAA_BEEF);
      if (c == 5) check_val("b2b_data2", bus.m0_data_o, 32'h0505_0505);
      to_drive();
      if (c == 2) drive(1'b0, 1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
      if (c == 5) drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end

    // reset asserted during ACCESS of a write to 0x20
    to_drive();
    drive(1'b0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h1234_5678);
    to_drive();
    rst = 1'b1;
    to_sample();
    check_val("rstacc_ce", {31'b0, bus.ram_ce_o}, 32'd0);
    to_drive();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    to_sample();
    check_val("rstacc_acks", {30'b0, bus.m1_ack_o, bus.m0_ack_o}, 32'h0);
    check_val("rstacc_m0_data", bus.m0_data_o, 32'h0);
    check_val("rstacc_m1_data", bus.m1_data_o, 32'h0);
    check_val("rstacc_ram", {bus.ram_ce_o, bus.ram_we_o, bus.ram_sel_o, bus.ram_addr_o[25:0]}, 32'h0);
    check_val("rstacc_wdata", bus.ram_data_o, 32'h0);
    check_val("rstacc_stall", {31'b0, bus.m0_stallreq_o}, 32'd0);
    to_drive();
    to_sample();
    check_val("rstacc_noack", {30'b0, bus.m1_ack_o, bus.m0_ack_o}, 32'h0);
    access("post_rst_rd", 1'b0, 1'b0, 32'h20, 4'hF, 32'h0, 32'h0808_0808);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
